// File: rtl/dram_arbiter.sv
// dram_arbiter: two-core arbiter in front of a single-port DRAM with a
// one-cycle registered read. Requests are level signals held until acq.
//
// Ports (2-entry buses: upper slice / bit 1 = core0, lower / bit 0 = core1)
//   CLK         system clock, rising edge
//   rst_n       synchronous active-low reset
//   rden, wren  per-core read / write request (both set = write)
//   Address     per-core address, 2*AW
//   Din         per-core write data, 2*DW
//   RAMq        DRAM read data
//   acq         per-core one-cycle completion pulse
//   Dq          per-core read data, held until that core's next read
//   RAMAddress, RAMDin, RAMwren   registered DRAM port
//
// Build option: define DRAM_ARB_FIXED_PRI_EN for fixed priority (core0 wins
// every tie); otherwise round-robin on the last served core.
module dram_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [1:0]      rden,
  input  logic [1:0]      wren,
  input  logic [2*AW-1:0] Address,
  input  logic [2*DW-1:0] Din,
  input  logic [DW-1:0]   RAMq,
  output logic [1:0]      acq,
  output logic [2*DW-1:0] Dq,
  output logic [AW-1:0]   RAMAddress,
  output logic [DW-1:0]   RAMDin,
  output logic            RAMwren
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  state_t     state;
  logic       owner;  // bus bit index of the core being served (1 = core0)
  logic [1:0] req;
  logic       win;

`ifndef DRAM_ARB_FIXED_PRI_EN
  logic       last;   // bus bit index of the last granted core
`endif

  // A core whose acq is high this cycle is masked so its still-held request
  // is not served a second time.
  always_comb begin
    req = (rden | wren) & ~acq;
`ifdef DRAM_ARB_FIXED_PRI_EN
    win = req[1];
`else
    if (req == 2'b11) win = ~last;
    else              win = req[1];
`endif
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      acq        <= '0;
      Dq         <= '0;
      RAMAddress <= '0;
      RAMDin     <= '0;
      RAMwren    <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRI_EN
      last       <= 1'b0;
`endif
    end else begin
      acq <= '0;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner      <= win;
`ifndef DRAM_ARB_FIXED_PRI_EN
            last       <= win;
`endif
            RAMAddress <= win ? Address[2*AW-1:AW] : Address[AW-1:0];
            RAMDin     <= win ? Din[2*DW-1:DW] : Din[DW-1:0];
            RAMwren    <= wren[win];
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // RAMwren doubles as the access-type flag for the current grant.
          if (RAMwren) begin
            RAMwren    <= 1'b0;
            acq[owner] <= 1'b1;
            state      <= IDLE;
          end else begin
            state      <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (owner) Dq[2*DW-1:DW] <= RAMq;
          else       Dq[DW-1:0]    <= RAMq;
          acq[owner] <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Testbench for dram_arbiter: directed stimulus, a transaction-level model
// compared every cycle, plus hand-computed literal checks.
module tb_dram_arbiter;

`ifdef DRAM_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        CLK;
  logic        rst_n;
  logic [1:0]  rden, wren;
  logic [7:0]  a0, a1, d0, d1;   // core0 / core1 address and write data
  logic [15:0] Address, Din;
  logic [7:0]  RAMq;
  logic [1:0]  acq;
  logic [15:0] Dq;
  logic [7:0]  RAMAddress, RAMDin;
  logic        RAMwren;

  assign Address = {a0, a1};
  assign Din     = {d0, d1};

  dram_arbiter #(.AW(8), .DW(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .rden(rden), .wren(wren),
    .Address(Address), .Din(Din), .RAMq(RAMq), .acq(acq), .Dq(Dq),
    .RAMAddress(RAMAddress), .RAMDin(RAMDin), .RAMwren(RAMwren)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DRAM: write on enable, registered read, not affected by reset.
  logic [7:0] dram [256];
  initial for (int i = 0; i < 256; i++) dram[i] = 8'(i) ^ 8'h5A;
  always @(posedge CLK) begin
    if (RAMwren) dram[RAMAddress] <= RAMDin;
    RAMq <= dram[RAMAddress];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each access is an occupancy countdown: a write completes 2 cycles after
  // its grant cycle, a read 3 cycles; completion raises acq for one cycle.
  logic [7:0] m_mem [256];
  initial for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
  bit         m_valid = 1'b0;
  int         m_busy, m_owner, m_last;   // core numbers: 0 = core0, 1 = core1
  bit         m_wr;
  logic [1:0] m_acq;
  logic [7:0] m_dq [2];
  logic [7:0] m_ramaddr, m_ramdin;
  logic       m_ramwren;

  always @(posedge CLK) begin : model
    bit r0, r1, wr;
    int c;
    if (m_valid && m_ramwren) m_mem[m_ramaddr] <= m_ramdin;
    if (!rst_n) begin
      m_valid   <= 1'b1;
      m_busy    <= 0;
      m_owner   <= 0;
      m_last    <= 1;
      m_wr      <= 1'b0;
      m_acq     <= 2'b00;
      m_dq[0]   <= 8'h00;
      m_dq[1]   <= 8'h00;
      m_ramaddr <= 8'h00;
      m_ramdin  <= 8'h00;
      m_ramwren <= 1'b0;
    end else if (m_valid) begin
      m_acq <= 2'b00;
      if (m_busy == 0) begin
        r0 = (rden[1] | wren[1]) & ~m_acq[1];
        r1 = (rden[0] | wren[0]) & ~m_acq[0];
        if (r0 || r1) begin
          if (r0 && r1) c = FIXED ? 0 : 1 - m_last;
          else          c = r0 ? 0 : 1;
          wr = (c == 0) ? wren[1] : wren[0];
          m_owner   <= c;
          m_last    <= c;
          m_wr      <= wr;
          m_ramaddr <= (c == 0) ? a0 : a1;
          m_ramdin  <= (c == 0) ? d0 : d1;
          m_ramwren <= wr;
          m_busy    <= wr ? 1 : 2;
        end
      end else begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_ramwren <= 1'b0;
          m_acq     <= (m_owner == 0) ? 2'b10 : 2'b01;
          if (!m_wr) m_dq[m_owner] <= m_mem[m_ramaddr];
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("acq",        {30'd0, acq},        {30'd0, m_acq});
      check("Dq",         {16'd0, Dq},         {16'd0, m_dq[0], m_dq[1]});
      check("RAMAddress", {24'd0, RAMAddress}, {24'd0, m_ramaddr});
      check("RAMDin",     {24'd0, RAMDin},     {24'd0, m_ramdin});
      check("RAMwren",    {31'd0, RAMwren},    {31'd0, m_ramwren});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rden  = 2'b00;
    wren  = 2'b00;
    tick(2);
    rst_n = 1'b1;
  endtask

  int  k_raise, wait_cyc, c1_between;
  bit  raised, served0, c1_wr;
  logic [1:0] first_bit, second_bit;

  initial begin
    rst_n = 1'b1; rden = 2'b00; wren = 2'b00;
    a0 = 8'h00; a1 = 8'h00; d0 = 8'h00; d1 = 8'h00;
    tick(1);
    rst_n = 1'b0;
    tick(2);
    check("rst_acq",  {30'd0, acq}, 32'h0);
    check("rst_Dq",   {16'd0, Dq}, 32'h0);
    check("rst_addr", {24'd0, RAMAddress}, 32'h0);
    check("rst_din",  {24'd0, RAMDin}, 32'h0);
    check("rst_wren", {31'd0, RAMwren}, 32'h0);
    rst_n = 1'b1;

    // core0 write 0xA5 to 0x10, then core1 reads it back
    wren = 2'b10; a0 = 8'h10; d0 = 8'hA5;
    tick(1);
    check("wr_cyc1_wren", {31'd0, RAMwren}, 32'h1);
    check("wr_cyc1_addr", {24'd0, RAMAddress}, 32'h10);
    check("wr_cyc1_din",  {24'd0, RAMDin}, 32'hA5);
    tick(1);
    check("wr_cyc2_acq", {30'd0, acq}, 32'h2);
    wren = 2'b00;
    tick(1);
    rden = 2'b01; a1 = 8'h10;
    tick(3);
    check("rd_cyc3_acq", {30'd0, acq}, 32'h1);
    check("rd_cyc3_dq1", {24'd0, Dq[7:0]}, 32'hA5);
    rden = 2'b00;
    tick(1);

    // simultaneous reads after reset: core0 first, core1 with no dead cycle
    do_reset();
    rden = 2'b11; a0 = 8'h01; a1 = 8'h02;
    tick(3);
    check("tie_c0_acq", {30'd0, acq}, 32'h2);
    check("tie_c0_dq",  {24'd0, Dq[15:8]}, 32'h5B);
    rden = 2'b01;
    tick(3);
    check("tie_c1_acq", {30'd0, acq}, 32'h1);
    check("tie_c1_dq",  {24'd0, Dq[7:0]}, 32'h58);
    rden = 2'b00;
    tick(1);

    // core0 served alone, then a tie: round-robin gives core1, fixed gives core0
    first_bit  = FIXED ? 2'b10 : 2'b01;
    second_bit = ~first_bit;
    for (int r = 0; r < 3; r++) begin
      rden = 2'b10; a0 = 8'(8'h03 + r);
      tick(3);
      check("solo_c0_acq", {30'd0, acq}, 32'h2);
      rden = 2'b00;
      tick(1);
      rden = 2'b11; a0 = 8'(8'h04 + r); a1 = 8'(8'h08 + r);
      tick(3);
      check("retie_first", {30'd0, acq}, {30'd0, first_bit});
      rden = second_bit;
      tick(3);
      check("retie_second", {30'd0, acq}, {30'd0, second_bit});
      rden = 2'b00;
      tick(1);
    end

    // core0 read+write together is a write: acq in cycle 2, Dq untouched
    do_reset();
    rden = 2'b10; wren = 2'b10; a0 = 8'h20; d0 = 8'h3C;
    tick(1);
    check("rw_cyc1_wren", {31'd0, RAMwren}, 32'h1);
    check("rw_cyc1_addr", {24'd0, RAMAddress}, 32'h20);
    check("rw_cyc1_din",  {24'd0, RAMDin}, 32'h3C);
    tick(1);
    check("rw_cyc2_acq", {30'd0, acq}, 32'h2);
    check("rw_cyc2_dq",  {16'd0, Dq}, 32'h0);
    rden = 2'b00; wren = 2'b00;
    tick(1);
    check("rw_cyc3_wren", {31'd0, RAMwren}, 32'h0);

    // core1 alternates write/read continuously; core0 asks once
    do_reset();
    c1_wr = 1'b1; wren = 2'b01; a1 = 8'h40; d1 = 8'hBF;
    raised = 1'b0; served0 = 1'b0; c1_between = 0; wait_cyc = 99; k_raise = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (acq[0]) begin
        if (raised && !served0) c1_between++;
        c1_wr   = ~c1_wr;
        wren[0] = c1_wr;
        rden[0] = ~c1_wr;
        a1      = a1 + 8'h01;
        d1      = ~a1;
      end
      if (acq[1] && raised && !served0) begin
        rden[1]  = 1'b0;
        served0  = 1'b1;
        wait_cyc = k - k_raise;
      end
      if (k == 7) begin
        rden[1] = 1'b1; a0 = 8'h41; raised = 1'b1; k_raise = k;
      end
    end
    check("starve_served", {31'd0, served0}, 32'h1);
    check("starve_c1_ahead_le1", {31'd0, (c1_between <= 1)}, 32'h1);
    check("starve_latency_le6", {31'd0, (wait_cyc <= 6)}, 32'h1);

    // reset during RDWAIT of a core0 read, request held across reset
    do_reset();
    rden = 2'b10; a0 = 8'h01;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("rdrst_acq",  {30'd0, acq}, 32'h0);
    check("rdrst_dq",   {16'd0, Dq}, 32'h0);
    check("rdrst_addr", {24'd0, RAMAddress}, 32'h0);
    check("rdrst_din",  {24'd0, RAMDin}, 32'h0);
    check("rdrst_wren", {31'd0, RAMwren}, 32'h0);
    rst_n = 1'b1;
    tick(2);
    check("rdrst_noacq", {30'd0, acq}, 32'h0);
    tick(1);
    check("rdrst_reacq", {30'd0, acq}, 32'h2);
    check("rdrst_redq",  {24'd0, Dq[15:8]}, 32'h5B);
    rden = 2'b00;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
